// File: rtl/jtkcpu_intctl.sv
// Interrupt arbiter and entry sequencer for the KCPU core: NMI > FIRQ > IRQ, taken at ni.
// Latency: 6 cen cycles from the accepting ni to pc_ld with no push or memory wait states.
// Backpressure: stalls in WAITP while psh_busy=1 and in VECHI/VECLO while mem_busy=1; cen=0 freezes all.
module jtkcpu_intctl #(
    parameter logic [15:0] VEC_FIRQ = 16'hFFF6,
    parameter logic [15:0] VEC_IRQ  = 16'hFFF8,
    parameter logic [15:0] VEC_NMI  = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        nmi,
    input  logic        firq,
    input  logic        irq,
    input  logic [7:0]  cc,
    input  logic        ni,
    input  logic        s_loaded,
    input  logic        psh_busy,
    input  logic        mem_busy,
    input  logic [7:0]  din,
    output logic        int_req,
    output logic        busy,
    output logic [1:0]  src,
    output logic        set_e,
    output logic        clr_e,
    output logic        set_i,
    output logic        set_f,
    output logic        psh_go,
    output logic        psh_all,
    output logic        vec_rd,
    output logic [15:0] vec_addr,
    output logic        pc_ld,
    output logic [15:0] pc_new
);

    typedef enum logic [2:0] {
        S_IDLE, S_CCE, S_PUSH, S_WAITP, S_MASK, S_VECHI, S_VECLO, S_LOAD
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_IRQ  = 2'd1;
    localparam logic [1:0] SRC_FIRQ = 2'd2;
    localparam logic [1:0] SRC_NMI  = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic        r_nmi_arm;
    logic        r_nmi_pend;
    logic        r_nmi_l;
    logic [1:0]  r_src;
    logic [15:0] r_pc_new;
    logic        w_firq_q;
    logic        w_irq_q;
    logic        w_nmi_edge;
    logic        w_accept;
    logic [15:0] w_base;
    logic        w_unused_cc;

    // Only the F and I mask bits qualify requests; E is written, never read here.
    assign w_unused_cc = ^{cc[7], cc[5], cc[3:0]};

    assign w_firq_q   = firq & ~cc[6];
    assign w_irq_q    = irq & ~cc[4];
    assign w_nmi_edge = nmi & ~r_nmi_l & r_nmi_arm;
    assign int_req    = (r_nmi_pend | w_firq_q | w_irq_q) & (r_state == S_IDLE);
    assign w_accept   = (r_state == S_IDLE) & ni & int_req;
    assign busy       = (r_state != S_IDLE);
    assign src        = r_src;
    assign pc_new     = r_pc_new;

    // Vector base follows the latched source, so late mask/request changes cannot redirect it.
    always_comb begin
        case (r_src)
            SRC_NMI:  w_base = VEC_NMI;
            SRC_FIRQ: w_base = VEC_FIRQ;
            default:  w_base = VEC_IRQ;
        endcase
    end

    // State register; synchronous reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst)      r_state <= S_IDLE;
        else if (cen) r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ni && int_req) w_next = S_CCE;
            S_CCE:   w_next = S_PUSH;
            S_PUSH:  w_next = S_WAITP;
            S_WAITP: if (!psh_busy) w_next = S_MASK;
            S_MASK:  w_next = S_VECHI;
            S_VECHI: if (!mem_busy) w_next = S_VECLO;
            S_VECLO: if (!mem_busy) w_next = S_LOAD;
            S_LOAD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode; every strobe is gated with cen so a frozen cycle emits nothing.
    always_comb begin
        set_e    = 1'b0;
        clr_e    = 1'b0;
        set_i    = 1'b0;
        set_f    = 1'b0;
        psh_go   = 1'b0;
        psh_all  = 1'b0;
        vec_rd   = 1'b0;
        pc_ld    = 1'b0;
        vec_addr = 16'h0000;
        case (r_state)
            S_CCE: begin
                set_e = cen & (r_src != SRC_FIRQ);
                clr_e = cen & (r_src == SRC_FIRQ);
            end
            S_PUSH: begin
                psh_go  = cen;
                psh_all = cen & (r_src != SRC_FIRQ);
            end
            S_MASK: begin
                set_i = cen;
                set_f = cen & ((r_src == SRC_NMI) | (r_src == SRC_FIRQ));
            end
            S_VECHI: begin
                vec_rd   = cen;
                vec_addr = w_base;
            end
            S_VECLO: begin
                vec_rd   = cen;
                vec_addr = w_base + 16'd1;
            end
            S_LOAD:  pc_ld = cen;
            default: ;
        endcase
    end

    // NMI arming/edge capture, source latch and vector assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nmi_arm  <= 1'b0;
            r_nmi_pend <= 1'b0;
            r_nmi_l    <= 1'b0;
            r_src      <= SRC_NONE;
            r_pc_new   <= 16'h0000;
        end else if (cen) begin
            r_nmi_l <= nmi;
            if (s_loaded) r_nmi_arm <= 1'b1;
            // A fresh edge wins over the clear so a second NMI is never lost.
            if (w_nmi_edge)
                r_nmi_pend <= 1'b1;
            else if (w_accept && r_nmi_pend)
                r_nmi_pend <= 1'b0;
            if (w_accept) begin
                if (r_nmi_pend)    r_src <= SRC_NMI;
                else if (w_firq_q) r_src <= SRC_FIRQ;
                else               r_src <= SRC_IRQ;
            end else if (r_state == S_LOAD) begin
                r_src <= SRC_NONE;
            end
            if (r_state == S_VECHI && !mem_busy) r_pc_new[15:8] <= din;
            if (r_state == S_VECLO && !mem_busy) r_pc_new[7:0]  <= din;
        end
    end

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Directed bench for jtkcpu_intctl: NMI arming, FIRQ/IRQ masking, priority, stalls, cen gating, reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Every wait on the DUT is bounded by a cycle budget.
module tb_jtkcpu_intctl;
    logic        clk = 1'b0;
    logic        rst, cen, nmi, firq, irq, ni, s_loaded, psh_busy, mem_busy;
    logic [7:0]  cc, din;
    logic        int_req, busy, set_e, clr_e, set_i, set_f, psh_go, psh_all, vec_rd, pc_ld;
    logic [1:0]  src;
    logic [15:0] vec_addr, pc_new;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    jtkcpu_intctl dut (
        .clk(clk), .rst(rst), .cen(cen), .nmi(nmi), .firq(firq), .irq(irq), .cc(cc),
        .ni(ni), .s_loaded(s_loaded), .psh_busy(psh_busy), .mem_busy(mem_busy), .din(din),
        .int_req(int_req), .busy(busy), .src(src), .set_e(set_e), .clr_e(clr_e),
        .set_i(set_i), .set_f(set_f), .psh_go(psh_go), .psh_all(psh_all), .vec_rd(vec_rd),
        .vec_addr(vec_addr), .pc_ld(pc_ld), .pc_new(pc_new)
    );

    // Advance one clock; return 1 unit after the edge so inputs can be changed safely.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    // Drive a zero-wait sequence from CCE to LOAD; din returns the low byte of the address.
    task automatic run_to_load(output int lat, output bit seen);
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            din = vec_addr[7:0];
            settle();
            if (pc_ld) seen = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; nmi = 0; firq = 0; irq = 0; ni = 0; s_loaded = 0;
        psh_busy = 0; mem_busy = 0; cc = 8'h00; din = 8'h00;
        tick(); tick();
        rst = 1'b0;
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", src); end
        checks++; if (pc_new !== 16'h0000) begin errors++; $display("FAIL reset_pc_new got %h exp 0000", pc_new); end
        checks++; if ({int_req, pc_ld, psh_go, vec_rd, set_e, clr_e, set_i, set_f} !== 8'h00)
            begin errors++; $display("FAIL reset_strobes got %b exp 00000000", {int_req, pc_ld, psh_go, vec_rd, set_e, clr_e, set_i, set_f}); end
    endtask

    task automatic test_nmi();
        // Edge before S is loaded must be discarded.
        nmi = 1; tick(); nmi = 0; tick();
        settle();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL nmi_unarmed got %b exp 0", int_req); end
        s_loaded = 1; tick();
        nmi = 1; tick(); nmi = 0;
        settle();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL nmi_pend got %b exp 1", int_req); end
        ni = 1; tick(); ni = 0; settle();
        checks++; if (src !== 2'd3 || set_e !== 1'b1 || clr_e !== 1'b0)
            begin errors++; $display("FAIL nmi_cce got src=%0d e=%b%b exp 3 10", src, set_e, clr_e); end
        tick();
        checks++; if (psh_go !== 1'b1 || psh_all !== 1'b1)
            begin errors++; $display("FAIL nmi_push got %b%b exp 11", psh_go, psh_all); end
        tick(); tick();
        checks++; if (set_i !== 1'b1 || set_f !== 1'b1)
            begin errors++; $display("FAIL nmi_mask got %b%b exp 11", set_i, set_f); end
        tick(); din = 8'h12; settle();
        checks++; if (vec_rd !== 1'b1 || vec_addr !== 16'hFFFC)
            begin errors++; $display("FAIL nmi_vechi got %b %h exp 1 fffc", vec_rd, vec_addr); end
        tick(); din = 8'h34; settle();
        checks++; if (vec_addr !== 16'hFFFD || pc_new !== 16'h1200)
            begin errors++; $display("FAIL nmi_veclo got %h %h exp fffd 1200", vec_addr, pc_new); end
        tick();
        checks++; if (pc_ld !== 1'b1 || pc_new !== 16'h1234)
            begin errors++; $display("FAIL nmi_load got %b %h exp 1 1234", pc_ld, pc_new); end
        tick();
        checks++; if (busy !== 1'b0 || src !== 2'd0 || pc_ld !== 1'b0 || int_req !== 1'b0)
            begin errors++; $display("FAIL nmi_done got %b %0d %b %b exp 0 0 0 0", busy, src, pc_ld, int_req); end
    endtask

    task automatic test_firq_wait();
        cc = 8'h00; firq = 1; settle();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL firq_req got %b exp 1", int_req); end
        ni = 1; tick(); ni = 0;
        firq = 0; cc = 8'h50;  // removal and masking after acceptance must not matter
        settle();
        checks++; if (src !== 2'd2 || clr_e !== 1'b1 || set_e !== 1'b0)
            begin errors++; $display("FAIL firq_cce got src=%0d e=%b%b exp 2 01", src, set_e, clr_e); end
        tick();
        checks++; if (psh_go !== 1'b1 || psh_all !== 1'b0)
            begin errors++; $display("FAIL firq_push got %b%b exp 10", psh_go, psh_all); end
        psh_busy = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (set_i !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL firq_waitp%0d got set_i=%b busy=%b exp 0 1", i, set_i, busy); end
        end
        psh_busy = 0; tick();
        checks++; if (set_i !== 1'b1 || set_f !== 1'b1)
            begin errors++; $display("FAIL firq_mask got %b%b exp 11", set_i, set_f); end
        tick(); din = 8'hAB; settle();
        checks++; if (vec_addr !== 16'hFFF6) begin errors++; $display("FAIL firq_vechi got %h exp fff6", vec_addr); end
        tick(); din = 8'hCD; settle();
        checks++; if (vec_addr !== 16'hFFF7) begin errors++; $display("FAIL firq_veclo got %h exp fff7", vec_addr); end
        tick();
        checks++; if (pc_ld !== 1'b1 || pc_new !== 16'hABCD)
            begin errors++; $display("FAIL firq_load got %b %h exp 1 abcd", pc_ld, pc_new); end
        tick(); cc = 8'h00;
    endtask

    task automatic test_irq_mask();
        int lat;
        bit seen;
        irq = 1; cc = 8'h10; settle();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL irq_masked_req got %b exp 0", int_req); end
        ni = 1; tick(); ni = 0; settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL irq_masked_busy got %b exp 0", busy); end
        cc = 8'h00; settle();
        checks++; if (int_req !== 1'b1) begin errors++; $display("FAIL irq_req got %b exp 1", int_req); end
        ni = 1; tick(); ni = 0; irq = 0; settle();
        checks++; if (src !== 2'd1 || set_e !== 1'b1)
            begin errors++; $display("FAIL irq_cce got src=%0d set_e=%b exp 1 1", src, set_e); end
        tick(); tick(); tick();
        checks++; if (set_i !== 1'b1 || set_f !== 1'b0)
            begin errors++; $display("FAIL irq_mask got %b%b exp 10", set_i, set_f); end
        run_to_load(lat, seen);
        checks++; if (!seen || pc_new !== 16'hF8F9)
            begin errors++; $display("FAIL irq_load got seen=%b %h exp 1 f8f9", seen, pc_new); end
        tick();
    endtask

    task automatic test_priority();
        int lat;
        bit seen;
        logic [1:0]  exp_src [3] = '{2'd3, 2'd2, 2'd1};
        logic [15:0] exp_pc  [3] = '{16'hFCFD, 16'hF6F7, 16'hF8F9};
        firq = 1; irq = 1; cc = 8'h00;
        nmi = 1; tick(); nmi = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) firq = 0;  // FIRQ has been served; leave only IRQ
            settle();
            ni = 1; tick(); ni = 0; settle();
            checks++; if (src !== exp_src[k])
                begin errors++; $display("FAIL prio_src%0d got %0d exp %0d", k, src, exp_src[k]); end
            run_to_load(lat, seen);
            checks++; if (!seen || lat != 6 || pc_new !== exp_pc[k])
                begin errors++; $display("FAIL prio_load%0d got seen=%b lat=%0d %h exp 1 6 %h", k, seen, lat, pc_new, exp_pc[k]); end
            tick();
        end
        irq = 0; settle();
        checks++; if (int_req !== 1'b0) begin errors++; $display("FAIL prio_idle got %b exp 0", int_req); end
    endtask

    task automatic test_cen_mem();
        int  hi_n = 0;
        int  lo_n = 0;
        int  ld_n = 0;
        logic [15:0] got = 16'h0;
        irq = 1; cc = 8'h00;
        ni = 1; tick(); ni = 0; irq = 0;
        for (int i = 0; i < 80 && ld_n == 0; i++) begin
            cen = (i % 2 == 0);
            // Hold mem_busy for 6 clocks per byte, i.e. 3 enabled cycles.
            mem_busy = 1'b0;
            if (vec_addr == 16'hFFF8) begin din = 8'h9A; mem_busy = (hi_n < 6); hi_n++; end
            if (vec_addr == 16'hFFF9) begin din = 8'hBC; mem_busy = (lo_n < 6); lo_n++; end
            settle();
            if (!cen) begin
                checks++; if ({pc_ld, psh_go, psh_all, vec_rd, set_e, clr_e, set_i, set_f} !== 8'h00)
                    begin errors++; $display("FAIL cen_gate%0d got %b exp 00000000", i, {pc_ld, psh_go, psh_all, vec_rd, set_e, clr_e, set_i, set_f}); end
            end else if (pc_ld) begin
                ld_n++;
                got = pc_new;
            end
            tick();
        end
        cen = 1; mem_busy = 0;
        checks++; if (ld_n != 1 || got !== 16'h9ABC)
            begin errors++; $display("FAIL cen_load got n=%0d %h exp 1 9abc", ld_n, got); end
        checks++; if (hi_n < 6 || lo_n < 6)
            begin errors++; $display("FAIL cen_memwait got hi=%0d lo=%0d exp >=6 >=6", hi_n, lo_n); end
        settle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cen_idle got %b exp 0", busy); end
    endtask

    task automatic test_rst_mid();
        int ld_n = 0;
        irq = 1; cc = 8'h00;
        ni = 1; tick(); ni = 0; irq = 0;
        tick(); psh_busy = 1; tick(); tick();
        settle();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_in_waitp got %b exp 1", busy); end
        rst = 1; tick(); rst = 0; psh_busy = 0; s_loaded = 0;
        settle();
        checks++; if (busy !== 1'b0 || src !== 2'd0)
            begin errors++; $display("FAIL rst_abort got busy=%b src=%0d exp 0 0", busy, src); end
        // Arming was cleared: an NMI edge with s_loaded low must not be pended.
        nmi = 1; tick(); nmi = 0; tick();
        for (int i = 0; i < 8; i++) begin
            ni = 1; settle();
            if (pc_ld) ld_n++;
            tick();
        end
        ni = 0; settle();
        checks++; if (int_req !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_disarm got req=%b busy=%b exp 0 0", int_req, busy); end
        checks++; if (ld_n != 0) begin errors++; $display("FAIL rst_no_pcld got %0d exp 0", ld_n); end
    endtask

    initial begin
        test_reset();
        test_nmi();
        test_firq_wait();
        test_irq_mask();
        test_priority();
        test_cen_mem();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtkcpu_intctl.md
Name: jtkcpu_intctl

Overview:
Interrupt arbiter and entry sequencer for the KCPU core. Qualifies NMI, FIRQ and IRQ against the CC masks and picks one by priority at an instruction boundary. It then drives the push/pull unit to stack the machine state, sets the CC mask bits, fetches the 16-bit vector over the 8-bit bus and hands the new PC to the control block. It sits beside the microcode sequencer and shares the push/pull unit and memory port with it.

Parameters:
VEC_FIRQ, 16'hFFF6, FIRQ vector address (high byte; low byte at +1)
VEC_IRQ, 16'hFFF8, IRQ vector address
VEC_NMI, 16'hFFFC, NMI vector address

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cen  in  1  clock enable; all state advances only when cen=1
nmi  in  1  NMI request, active-high, edge-triggered
firq  in  1  FIRQ request, active-high, level
irq  in  1  IRQ request, active-high, level
cc  in  8  condition codes (bit7 E, bit6 F, bit4 I)
ni  in  1  next-instruction strobe from microcode (instruction boundary)
s_loaded  in  1  high once S has been written; arms NMI
psh_busy  in  1  push/pull unit busy
mem_busy  in  1  memory read not yet complete
din  in  8  memory read data
int_req  out  1  an interrupt will be taken at the next ni
busy  out  1  entry sequence in progress (state != IDLE)
src  out  2  accepted source: 0 none, 1 IRQ, 2 FIRQ, 3 NMI
set_e  out  1  set CC.E
clr_e  out  1  clear CC.E
set_i  out  1  set CC.I
set_f  out  1  set CC.F
psh_go  out  1  one-cycle start pulse to push/pull unit
psh_all  out  1  push full state (1) or PC+CC only (0); valid with psh_go
vec_rd  out  1  vector read request
vec_addr  out  16  vector byte address
pc_ld  out  1  one-cycle PC load strobe
pc_new  out  16  vector value, valid while pc_ld=1

Behaviour:
- Reset: state IDLE, nmi_arm=0, nmi_pend=0, nmi_l=0, src=0, pc_new=0, all strobes 0. Reset mid-sequence aborts to IDLE with no pc_ld.
- NMI arming: nmi_arm is set on the first cen cycle with s_loaded=1 and stays set until rst.
- NMI edge detect: nmi_l<=nmi on each cen. nmi & ~nmi_l & nmi_arm sets nmi_pend.
- An edge arriving while a sequence is busy is kept pending. Edges before arming are discarded.
- nmi_pend clears only when NMI is accepted.
- Qualification (combinational):
  - firq_q = firq & ~cc[6]
  - irq_q = irq & ~cc[4]
  - Priority: NMI > FIRQ > IRQ.
- int_req = (nmi_pend | firq_q | irq_q) & (state==IDLE).
- FSM (transitions only on cen):
  - IDLE: on ni & int_req, latch src by priority and go to CCE. Level requests that drop before ni are not taken.
  - CCE (1 cycle): set_e=1 for NMI/IRQ, clr_e=1 for FIRQ. This ensures the stacked CC carries the right E.
  - PUSH (1 cycle): psh_go=1, psh_all=(src!=2).
  - WAITP: hold while psh_busy=1; go to MASK on the first cycle with psh_busy=0. psh_busy is first sampled in the cycle after psh_go.
  - MASK (1 cycle): set_i=1 always; set_f=1 for NMI and FIRQ.
  - VECHI: vec_rd=1, vec_addr=base. While mem_busy=0, latch pc_new[15:8]<=din and go to VECLO.
  - VECLO: vec_rd=1, vec_addr=base+1. While mem_busy=0, latch pc_new[7:0]<=din and go to LOAD.
  - LOAD (1 cycle): pc_ld=1; then go to IDLE and set src=0.
- Minimum latency from accepting ni to pc_ld: 6 cen cycles, with zero push and memory wait.
- cen=0 freezes all state and suppresses every strobe (strobes are gated with cen).
- Mask changes or request removal after acceptance do not affect an accepted sequence.
- A higher-priority request arriving mid-sequence waits for the next ni after return to IDLE.

Test Plan:
- NMI before s_loaded, then s_loaded=1 and a second NMI rising edge at ni -> first edge ignored; second gives src=3, set_e, psh_go with psh_all=1, set_i+set_f, vec_addr FFFC then FFFD, pc_ld with pc_new=din pair (e.g. 12,34 -> 16'h1234).
- firq=1, cc=8'h00, psh_busy high 5 cycles -> clr_e, psh_all=0, MASK held until psh_busy=0, vector FFF6/FFF7, set_f=1.
- irq=1 with cc[4]=1 -> int_req=0, no sequence; clear cc[4] -> taken at next ni, src=1, set_f=0.
- nmi edge, firq and irq all asserted at the same ni -> NMI served first; FIRQ taken at the following ni; IRQ after that, provided the CC bits allow it.
- mem_busy=1 for 3 cycles on each vector byte, cen toggling 50% -> correct pc_new; no strobe while cen=0.
- rst asserted during WAITP -> state IDLE, no pc_ld, nmi_arm cleared.
